led_seq_ctrl: RTL and testbench

- Controller that sequences the LED counter from a single system clock, using a programmable prescaler that emits one-cycle tick enables.
- No derived clocks.
- Accepts commands over a valid/ready handshake: start, stop, single-step, period, direction, clear and load.
- Sits between SOC-level control logic and the LEDS output, replacing the free-running divided-clock counter.

---
 rtl/led_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED counter sequencer with prescaled tick and command handshake
// Optional LEDSEQ_BOUNCE_EN: reverse direction at the counter ends instead of wrapping.
module led_seq_ctrl #(
  parameter int          WIDTH      = 5,
  parameter int          DIV_BITS   = 23,
  parameter int unsigned PERIOD_RST = 4194303
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [DIV_BITS-1:0] cmd_arg,
  output logic [WIDTH-1:0]    LEDS,
  output logic                tick,
  output logic [1:0]          state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [2:0] OP_START      = 3'd1;
  localparam logic [2:0] OP_STOP       = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_SET_PERIOD = 3'd4;
  localparam logic [2:0] OP_SET_DIR    = 3'd5;
  localparam logic [2:0] OP_CLEAR      = 3'd6;
  localparam logic [2:0] OP_LOAD       = 3'd7;

  logic [1:0]          state_q, state_d;
  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [DIV_BITS-1:0] period_q, period_d;
  logic                dir_q, dir_d;
  logic [WIDTH-1:0]    leds_q, leds_d;
  logic                tick_q, tick_d;
  logic                counting, expire, accept;

  assign cmd_ready = (state_q != ST_STEP);
  assign LEDS      = leds_q;
  assign tick      = tick_q;
  assign state     = state_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    period_d = period_q;
    dir_d    = dir_q;
    leds_d   = leds_q;
    counting = (state_q != ST_IDLE);
    expire   = counting && (presc_q == period_q);
    accept   = cmd_valid && cmd_ready;
    tick_d   = expire;

    if (!counting)   presc_d = '0;
    else if (expire) presc_d = '0;
    else             presc_d = presc_q + DIV_BITS'(1);

    if (expire) begin
`ifdef LEDSEQ_BOUNCE_EN
      if (!dir_q && (leds_q == '1)) begin
        leds_d = leds_q - WIDTH'(1);
        dir_d  = 1'b1;
      end else if (dir_q && (leds_q == '0)) begin
        leds_d = WIDTH'(1);
        dir_d  = 1'b0;
      end else begin
        leds_d = dir_q ? leds_q - WIDTH'(1) : leds_q + WIDTH'(1);
      end
`else
      leds_d = dir_q ? leds_q - WIDTH'(1) : leds_q + WIDTH'(1);
`endif
      if (state_q == ST_STEP) state_d = ST_IDLE;
    end

    // Commands are evaluated after the tick so LEDS writes and SET_DIR take precedence.
    if (accept) begin
      case (cmd_op)
        OP_START: if (state_q == ST_IDLE) state_d = ST_RUN;
        OP_STOP: begin
          if (state_q == ST_RUN) begin
            state_d = ST_IDLE;
            presc_d = '0;
          end
        end
        OP_STEP: begin
          if (state_q == ST_IDLE) begin
            state_d = ST_STEP;
            presc_d = '0;
          end
        end
        OP_SET_PERIOD: begin
          period_d = cmd_arg;
          presc_d  = '0;
        end
        OP_SET_DIR: dir_d = cmd_arg[0];
        OP_CLEAR: begin
          leds_d  = '0;
          presc_d = '0;
        end
        OP_LOAD: begin
          leds_d  = cmd_arg[WIDTH-1:0];
          presc_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      period_q <= DIV_BITS'(PERIOD_RST);
      dir_q    <= 1'b0;
      leds_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      leds_q   <= leds_d;
      tick_q   <= tick_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed self-checking bench for led_seq_ctrl
// Bounce expectations are selected with LEDSEQ_BOUNCE_EN to match the RTL build.
module tb_led_seq_ctrl;

  localparam int W  = 5;
  localparam int DB = 23;
  localparam int PR = 6;

  localparam logic [2:0] OP_START      = 3'd1;
  localparam logic [2:0] OP_STOP       = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_SET_PERIOD = 3'd4;
  localparam logic [2:0] OP_SET_DIR    = 3'd5;
  localparam logic [2:0] OP_CLEAR      = 3'd6;
  localparam logic [2:0] OP_LOAD       = 3'd7;

  logic          CLK;
  logic          RESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DB-1:0] cmd_arg;
  logic [W-1:0]  LEDS;
  logic          tick;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  led_seq_ctrl #(.WIDTH(W), .DIV_BITS(DB), .PERIOD_RST(PR)) dut (
    .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .LEDS(LEDS), .tick(tick), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [DB-1:0] arg);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (!cmd_ready && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) check("send_ready_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = '0;
  endtask

  logic [W-1:0] exp3 [4];
  int           exp1;

  initial begin
`ifdef LEDSEQ_BOUNCE_EN
    exp3[0] = 5'd1; exp3[1] = 5'd0; exp3[2] = 5'd1; exp3[3] = 5'd2;
`else
    exp3[0] = 5'd1; exp3[1] = 5'd0; exp3[2] = 5'd31; exp3[3] = 5'd30;
`endif
    RESET = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0;
    repeat (3) step();
    check("rst_leds", 32'(LEDS), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    RESET = 1'b1;
    step();

    // Free run at period 3: a tick every 4 cycles, wrap after 32 ticks.
    send(OP_SET_PERIOD, 23'd3);
    send(OP_START, '0);
    check("run_state", 32'(state), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        check($sformatf("run_gap_tick_%0d_%0d", k, j), 32'(tick), 32'd0);
      end
      step();
      check($sformatf("run_tick_%0d", k), 32'(tick), 32'd1);
`ifdef LEDSEQ_BOUNCE_EN
      exp1 = (k == 32) ? 30 : k;
`else
      exp1 = k % 32;
`endif
      check($sformatf("run_leds_%0d", k), 32'(LEDS), 32'(exp1));
    end
    send(OP_STOP, '0);
    check("stop_state", 32'(state), 32'd0);
    send(OP_CLEAR, '0);
    send(OP_SET_DIR, 23'd0);
    check("clear_leds", 32'(LEDS), 32'd0);

    // Single step at period 9: ready low for 10 cycles, then LEDS advances once.
    send(OP_SET_PERIOD, 23'd9);
    send(OP_STEP, '0);
    check("step_state", 32'(state), 32'd2);
    check("step_ready_0", 32'(cmd_ready), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("step_ready_%0d", i), 32'(cmd_ready), 32'd0);
      check($sformatf("step_leds_%0d", i), 32'(LEDS), 32'd0);
    end
    step();
    check("step_done_leds", 32'(LEDS), 32'd1);
    check("step_done_tick", 32'(tick), 32'd1);
    check("step_done_state", 32'(state), 32'd0);
    check("step_done_ready", 32'(cmd_ready), 32'd1);
    step();
    check("step_after_leds", 32'(LEDS), 32'd1);
    check("step_after_tick", 32'(tick), 32'd0);

    // Period 0 counting down from 2, through the low end.
    send(OP_SET_PERIOD, 23'd0);
    send(OP_LOAD, 23'd2);
    send(OP_SET_DIR, 23'd1);
    send(OP_START, '0);
    check("down_start_leds", 32'(LEDS), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("down_leds_%0d", i), 32'(LEDS), 32'(exp3[i]));
      check($sformatf("down_tick_%0d", i), 32'(tick), 32'd1);
    end

    // LOAD on a tick edge: write wins, tick still pulses.
    send(OP_SET_DIR, 23'd0);
    send(OP_LOAD, 23'd17);
    check("load_leds", 32'(LEDS), 32'd17);
    check("load_tick", 32'(tick), 32'd1);
    step();
    check("load_next_leds", 32'(LEDS), 32'd18);
    send(OP_STEP, '0);
    check("run_step_ignored_state", 32'(state), 32'd1);
    check("run_step_ignored_leds", 32'(LEDS), 32'd19);
    send(OP_STOP, '0);
    check("stop_tick_applies_leds", 32'(LEDS), 32'd20);
    check("stop_tick_applies_tick", 32'(tick), 32'd1);
    check("stop_idle_state", 32'(state), 32'd0);
    step();
    check("idle_hold_leds", 32'(LEDS), 32'd20);
    check("idle_hold_tick", 32'(tick), 32'd0);

    // Asynchronous reset in the middle of a period restores defaults.
    send(OP_SET_PERIOD, 23'd5);
    send(OP_SET_DIR, 23'd1);
    send(OP_START, '0);
    step();
    step();
    #3 RESET = 1'b0;
    #1;
    check("async_rst_leds", 32'(LEDS), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_ready", 32'(cmd_ready), 32'd1);
    check("async_rst_tick", 32'(tick), 32'd0);
    step();
    RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("post_rst_tick_%0d", i), 32'(tick), 32'd0);
    end
    send(OP_STEP, '0);
    for (int i = 1; i <= PR; i++) begin
      step();
      check($sformatf("rst_period_wait_%0d", i), 32'(LEDS), 32'd0);
    end
    step();
    check("rst_period_leds", 32'(LEDS), 32'd1);
    check("rst_period_state", 32'(state), 32'd0);

`ifdef LEDSEQ_BOUNCE_EN
    send(OP_SET_PERIOD, 23'd0);
    send(OP_LOAD, 23'd29);
    send(OP_START, '0);
    step(); check("bounce_30a", 32'(LEDS), 32'd30);
    step(); check("bounce_31", 32'(LEDS), 32'd31);
    step(); check("bounce_30b", 32'(LEDS), 32'd30);
    step(); check("bounce_29", 32'(LEDS), 32'd29);
    send(OP_LOAD, 23'd1);
    check("bounce_load", 32'(LEDS), 32'd1);
    send(OP_SET_DIR, 23'd1);
    check("bounce_0", 32'(LEDS), 32'd0);
    step(); check("bounce_1", 32'(LEDS), 32'd1);
    step(); check("bounce_2", 32'(LEDS), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
